alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle ALU for the multi-cycle RISC-V core, replacing the combinational ALU in the execute stage. It adds registered results, a start/done handshake, a wider operation set (xor, sltu, shifts) and iterative unsigned multiply/divide/remainder. Single-cycle ops complete one cycle after start; mul/div ops take WIDTH+1 cycles. The control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32: operand and result width, ≥ 8, power of two.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request; sampled only when `busy` = 0.
- `ALUControl`  in  4: operation, sampled with `start`.
- `a_in`  in  WIDTH: operand A, sampled with `start`.
- `b_in`  in  WIDTH: operand B, sampled with `start`.
- `busy`  out  1: iterative op in progress.
- `done`  out  1: one-cycle pulse, result valid.
- `ALUResult`  out  WIDTH: registered result; holds until the next `done`.
- `Z`  out  1: registered (`ALUResult` == 0); updates with `ALUResult`.

## Operation
- Op codes:
  - 0000 add; 0001 sub (a + ~b + 1); 0010 and; 0110 or; 0011 xor.
  - 0101 slt (signed); 0100 sltu.
  - 0111 sll; 1000 srl; 1001 sra. Shift amount = `b_in[$clog2(WIDTH)-1:0]`, upper bits ignored.
  - 1010 mul (low WIDTH bits); 1011 mulhu (high WIDTH bits, unsigned).
  - 1100 divu; 1101 remu.
  - 1110, 1111 reserved: result 0, `Z` = 1, single-cycle.
- Arithmetic: add/sub wrap modulo 2^WIDTH, no carry/overflow outputs. slt/sltu produce a zero-extended 1 or 0.
- FSM states:
  - IDLE: on `start`, a single-cycle op writes `ALUResult`/`Z` at that edge and `done` pulses in the next cycle. An iterative op latches the operands, clears the counter and moves to RUN.
  - RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle, WIDTH steps. On the last step, write `ALUResult`/`Z` and go to IDLE; `done` pulses in the next cycle.
- Divide by zero (divu, remu): no special timing; the iteration runs the full WIDTH steps. divu result = all ones; remu result = `a_in`.
- `start` while `busy` = 1 is ignored; it is not queued and operands are not re-sampled.
- `start` in the same cycle `done` is high is accepted (back-to-back issue).
- `reset` at any time, including mid-RUN: state IDLE, counter 0, all outputs 0, no `done` for the aborted op.

## Timing
- Reset values: `busy` = 0, `done` = 0, `ALUResult` = 0, `Z` = 0.
- Start sampled in cycle N, single-cycle op: `done` = 1 and result valid in cycle N+1.
- Start sampled in cycle N, iterative op:
  - `busy` = 1 in cycles N+1 … N+WIDTH.
  - `done` = 1 and result valid in cycle N+WIDTH+1.
  - `busy` = 0 in cycle N+WIDTH+1.
- `done` is never high for two consecutive cycles except on back-to-back single-cycle ops.
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`: op-code constants, FSM state encoding, and an `is_iterative(op)` helper.
- Sub-module `alu_muldiv_iter`:
  - Holds the operand, accumulator and remainder registers and the `$clog2(WIDTH)+1`-bit step counter.
  - Interface: `load`, `op`, operands, `step_done`, `hi`/`lo` result.
- `alu_seq`: FSM, single-cycle datapath, output registers.

## Test plan
- sub, a=5, b=5, start in cycle 0 → `done` in cycle 1, `ALUResult` = 0, `Z` = 1, `busy` never high.
- mul 7×6, then mulhu 0xFFFFFFFF×0xFFFFFFFF (WIDTH = 32) → 42 with `done` at cycle 33; then 0xFFFFFFFE; `busy` high for exactly 32 cycles each.
- divu 100/7 → 14; remu 100/7 → 2; divu 5/0 → 0xFFFFFFFF; remu 5/0 → 5; each op takes 33 cycles.
- sra 0x80000000 by b = 0x24 (amount 4) → 0xF8000000; srl same → 0x08000000; slt 0xFFFFFFFF,1 → 1; sltu same → 0.
- During divu, pulse `start` with add 1+1 at cycle 10 → ignored. Only one `done`, at cycle 33, with the divu result.
- Assert `reset` at cycle 15 of a mul, release, then issue add 2+3 → outputs 0 during reset, no stale `done`, add returns 5 one cycle after its start.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and op helpers
// for the multi-cycle execute-stage ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLTU  = 4'b0100;
  localparam logic [3:0] OP_SLT   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  function automatic logic is_iterative(
    input logic [3:0] op
  );
    return op inside {OP_MUL, OP_MULHU,
                      OP_DIVU, OP_REMU};
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return op inside {OP_DIVU, OP_REMU};
  endfunction

  function automatic logic sel_hi(
    input logic [3:0] op
  );
    return op inside {OP_MULHU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the control
// FSM (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Z;

  modport master (
    output start, ALUControl, a_in, b_in,
    input  busy, done, ALUResult, Z
  );

  modport slave (
    input  start, ALUControl, a_in, b_in,
    output busy, done, ALUResult, Z
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and
// restoring divide; one step per cycle, WIDTH steps.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_step_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             r_act;
  logic             r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rs;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_nhi;
  logic [WIDTH-1:0] w_nlo;

  // lo holds multiplier/dividend, b the
  // multiplicand/divisor, hi the acc/remainder
  always_comb begin
    w_sum  = {1'b0, r_hi}
           + (r_lo[0] ? {1'b0, r_b}
                      : {(WIDTH+1){1'b0}});
    w_rs   = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_rs - {1'b0, r_b};
    if (r_div) begin
      w_nhi = w_diff[WIDTH] ? w_rs[WIDTH-1:0]
                            : w_diff[WIDTH-1:0];
      w_nlo = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      w_nhi = w_sum[WIDTH:1];
      w_nlo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_hi = w_nhi;
  assign o_lo = w_nlo;
  assign o_step_done =
    r_act && (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (i_load) begin
      r_act <= 1'b1;
      r_div <= is_div(i_op);
      r_cnt <= '0;
      r_b   <= i_b;
      r_hi  <= '0;
      r_lo  <= i_a;
    end else if (r_act) begin
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
      if (o_step_done) begin
        r_act <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops plus
// iterative mul/div behind a start/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_res;
  logic             r_z;
  logic             r_done;

  logic             w_load;
  logic             w_wr;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_single;
  logic [WIDTH-1:0] w_iter;
  logic [SW-1:0]    w_sh;
  logic             w_step_done;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_sh = bus.b_in[SW-1:0];

  always_comb begin
    w_single = '0;
    case (bus.ALUControl)
      OP_ADD:  w_single = bus.a_in + bus.b_in;
      OP_SUB:  w_single = bus.a_in + ~bus.b_in
                        + WIDTH'(1);
      OP_AND:  w_single = bus.a_in & bus.b_in;
      OP_OR:   w_single = bus.a_in | bus.b_in;
      OP_XOR:  w_single = bus.a_in ^ bus.b_in;
      OP_SLT:  w_single = WIDTH'(
                 $signed(bus.a_in)
                 < $signed(bus.b_in));
      OP_SLTU: w_single = WIDTH'(
                 bus.a_in < bus.b_in);
      OP_SLL:  w_single = bus.a_in << w_sh;
      OP_SRL:  w_single = bus.a_in >> w_sh;
      OP_SRA:  w_single = WIDTH'(
                 $signed(bus.a_in) >>> w_sh);
      default: w_single = '0;
    endcase
  end

  assign w_iter = sel_hi(r_op) ? w_hi : w_lo;

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_wr   = 1'b0;
    w_res  = w_single;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (is_iterative(bus.ALUControl)) begin
            w_load = 1'b1;
            w_next = S_RUN;
          end else begin
            w_wr = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_step_done) begin
          w_wr   = 1'b1;
          w_res  = w_iter;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_res   <= '0;
      r_z     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_wr;
      if (w_load) r_op <= bus.ALUControl;
      if (w_wr) begin
        r_res <= w_res;
        r_z   <= (w_res == '0);
      end
    end
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_op       (bus.ALUControl),
    .i_a        (bus.a_in),
    .i_b        (bus.b_in),
    .o_step_done(w_step_done),
    .o_hi       (w_hi),
    .o_lo       (w_lo)
  );

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = r_done;
  assign bus.ALUResult = r_res;
  assign bus.Z         = r_z;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected results
// queued at issue, compared on each done pulse.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    int           cyc;
    int           busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   busy_cnt = 0;
  exp_t q[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h",
               tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_AND:   return a & b;
      OP_OR:    return a | b;
      OP_XOR:   return a ^ b;
      OP_SLT:   return ($signed(a) < $signed(b))
                       ? 32'd1 : 32'd0;
      OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:   return a << b[4:0];
      OP_SRL:   return a >> b[4:0];
      OP_SRA:   return $signed(a) >>> b[4:0];
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? '1 : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      default:  return '0;
    endcase
  endfunction

  task automatic issue(
    input logic [3:0]   op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t e;
    logic it;
    it = is_iterative(op);
    bus.start      = 1'b1;
    bus.ALUControl = op;
    bus.a_in       = a;
    bus.b_in       = b;
    e.res  = model(op, a, b);
    e.z    = (e.res == '0);
    e.cyc  = cyc + (it ? W + 1 : 1);
    e.busy = it ? W : 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || bus.busy)
           && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("timeout", q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", q.size(), 1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", bus.ALUResult, e.res);
          chk("z", bus.Z, e.z);
          chk("done_cyc", cyc, e.cyc);
          chk("busy_len", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    bus.start      = 1'b0;
    bus.ALUControl = '0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_res", bus.ALUResult, 0);
    chk("rst_z", bus.Z, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(OP_SUB, 5, 5);
    wait_idle();
    issue(OP_MUL, 7, 6);
    wait_idle();
    issue(OP_MULHU, '1, '1);
    wait_idle();
    issue(OP_DIVU, 100, 7);
    wait_idle();
    issue(OP_REMU, 100, 7);
    wait_idle();
    issue(OP_DIVU, 5, 0);
    wait_idle();
    issue(OP_REMU, 5, 0);
    wait_idle();
    issue(OP_SRA, 32'h8000_0000, 32'h24);
    issue(OP_SRL, 32'h8000_0000, 32'h24);
    issue(OP_SLT, '1, 1);
    issue(OP_SLTU, '1, 1);
    issue(4'b1110, 32'h1234, 32'h5678);
    issue(4'b1111, 32'h1, 32'h1);
    issue(OP_XOR, 32'hA5A5_0F0F, 32'hFFFF_0000);
    issue(OP_SLL, 32'h1, 32'hFFFF_FFFF);
    wait_idle();

    issue(OP_DIVU, 1000, 10);
    repeat (8) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.ALUControl = OP_ADD;
    bus.a_in       = 1;
    bus.b_in       = 1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle();

    issue(OP_MUL, 32'h1234, 32'h5678);
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_res", bus.ALUResult, 0);
    chk("mid_rst_z", bus.Z, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(OP_ADD, 2, 3);
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    chk("no_stale", q.size(), 0);

    for (int i = 0; i < 12; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? W'($urandom_range(0, 9))
                        : W'($urandom);
      issue(op, a, b);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
